// File: rtl/gray_code_counter.sv
// Up/down Gray code counter with parallel load and a choice of wrap or saturate at the bounds.
// Binary state and Gray output are registered together from the same next value, so they always agree.
module gray_code_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL1   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL0   = {WIDTH{1'b0}};

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             tc_q, tc_d;
  logic             at_max_q, at_max_d;
  logic             at_min_q, at_min_d;

  always_comb begin
    b_d  = b_q;
    tc_d = 1'b0;
    if (load) begin
      b_d = load_val;
    end else if (en) begin
      if (up) begin
        if (b_q != ALL1) begin
          b_d = b_q + ONE;
        end else if (WRAP) begin
          b_d  = ALL0;
          tc_d = 1'b1;
        end
      end else begin
        if (b_q != ALL0) begin
          b_d = b_q - ONE;
        end else if (WRAP) begin
          b_d  = ALL1;
          tc_d = 1'b1;
        end
      end
    end
    // Gray and flags come from the next binary value so every output describes the same count.
    g_d      = b_d ^ (b_d >> 1);
    at_max_d = (b_d == ALL1);
    at_min_d = (b_d == ALL0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q      <= ALL0;
      g_q      <= ALL0;
      tc_q     <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      b_q      <= b_d;
      g_q      <= g_d;
      tc_q     <= tc_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  assign b      = b_q;
  assign g      = g_q;
  assign tc     = tc_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: a wrapping and a saturating instance share one stimulus stream;
// table vectors and hand sequences carry fixed expectations, a scoreboard model checks every cycle.
module tb_gray_code_counter;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, up, load;
  logic [W-1:0] loadVal;
  logic [W-1:0] gW, bW, gS, bS;
  logic         tcW, mxW, mnW, tcS, mxS, mnS;

  gray_code_counter #(.WIDTH(W), .WRAP(1'b1)) dutWrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(loadVal),
    .g(gW), .b(bW), .tc(tcW), .at_max(mxW), .at_min(mnW)
  );

  gray_code_counter #(.WIDTH(W), .WRAP(1'b0)) dutSat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(loadVal),
    .g(gS), .b(bS), .tc(tcS), .at_max(mxS), .at_min(mnS)
  );

  typedef struct {
    logic       rst, en, up, load;
    logic [3:0] lv;
    logic [3:0] g, b;
    logic       tc, mx, mn;
  } vec_t;

  typedef struct {
    logic [3:0] wB, sB;
    logic       wTc, sTc;
    bit         step, sMoved;
    int         fixSel;
    logic [3:0] fG, fB;
    logic       fTc, fMx, fMn;
  } sb_t;

  vec_t       vecs[$];
  sb_t        sb[$];
  logic [3:0] mW, mS, lastWG, lastSG;
  int         nVec = 0;
  int         nMis = 0;

  function automatic logic [3:0] toGray(input logic [3:0] v);
    logic [3:0] r;
    r[3] = v[3];
    for (int i = 2; i >= 0; i--) r[i] = v[i+1] ^ v[i];
    return r;
  endfunction

  function automatic logic [3:0] grayToBin(input logic [3:0] v);
    logic [3:0] r;
    r[3] = v[3];
    for (int i = 2; i >= 0; i--) r[i] = r[i+1] ^ v[i];
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s at vector %0d: got %0h, expected %0h", name, nVec, act, exp);
    end
  endtask

  task automatic addVec(input logic r, e, u, l, input logic [3:0] lv, g, b,
                        input logic tc, mx, mn);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = lv;
    v.g = g; v.b = b; v.tc = tc; v.mx = mx; v.mn = mn;
    vecs.push_back(v);
  endtask

  task automatic modelNext(input bit wrap, input logic [3:0] cur,
                           output logic [3:0] nxt, output logic t);
    t   = 1'b0;
    nxt = cur;
    if (rst) nxt = 4'h0;
    else if (load) nxt = loadVal;
    else if (en) begin
      if (up) begin
        if (cur == 4'hF) begin
          if (wrap) begin nxt = 4'h0; t = 1'b1; end
        end else nxt = cur + 4'd1;
      end else begin
        if (cur == 4'h0) begin
          if (wrap) begin nxt = 4'hF; t = 1'b1; end
        end else nxt = cur - 4'd1;
      end
    end
  endtask

  task automatic checkOutput();
    sb_t s;
    s = sb.pop_front();
    nVec++;
    cmp("wrapB", bW, s.wB);
    cmp("wrapG", gW, toGray(s.wB));
    cmp("wrapTc", tcW, s.wTc);
    cmp("wrapMax", mxW, s.wB == 4'hF);
    cmp("wrapMin", mnW, s.wB == 4'h0);
    cmp("wrapConv", grayToBin(gW), bW);
    cmp("satB", bS, s.sB);
    cmp("satG", gS, toGray(s.sB));
    cmp("satTc", tcS, s.sTc);
    cmp("satMax", mxS, s.sB == 4'hF);
    cmp("satMin", mnS, s.sB == 4'h0);
    cmp("satConv", grayToBin(gS), bS);
    if (s.step) begin
      cmp("wrapStepBits", $countones(gW ^ lastWG), 1);
      cmp("satStepBits", $countones(gS ^ lastSG), s.sMoved ? 1 : 0);
    end
    if (s.fixSel == 1) begin
      cmp("tblWrapG", gW, s.fG);
      cmp("tblWrapB", bW, s.fB);
      cmp("tblWrapTc", tcW, s.fTc);
      cmp("tblWrapMax", mxW, s.fMx);
      cmp("tblWrapMin", mnW, s.fMn);
    end else if (s.fixSel == 2) begin
      cmp("seqSatG", gS, s.fG);
      cmp("seqSatB", bS, s.fB);
      cmp("seqSatTc", tcS, s.fTc);
      cmp("seqSatMax", mxS, s.fMx);
      cmp("seqSatMin", mnS, s.fMn);
    end
    lastWG = gW;
    lastSG = gS;
  endtask

  task automatic applyStimulus(input logic r, e, u, l, input logic [3:0] lv,
                               input int fixSel, input logic [3:0] fG, fB,
                               input logic fTc, fMx, fMn);
    sb_t        s;
    logic [3:0] nW, nS;
    logic       tW, tS;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; loadVal = lv;
    modelNext(1'b1, mW, nW, tW);
    modelNext(1'b0, mS, nS, tS);
    s.wB = nW; s.sB = nS; s.wTc = tW; s.sTc = tS;
    s.step   = !r && !l && e;
    s.sMoved = (nS != mS);
    s.fixSel = fixSel;
    s.fG = fG; s.fB = fB; s.fTc = fTc; s.fMx = fMx; s.fMn = fMn;
    mW = nW;
    mS = nS;
    sb.push_back(s);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  logic [3:0] grayUp [16];

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; loadVal = 4'h0;
    lastWG = 4'h0; lastSG = 4'h0;

    grayUp = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
               4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    addVec(1, 1, 1, 1, 4'b1010, 4'b0000, 4'b0000, 0, 0, 1);
    addVec(1, 1, 1, 1, 4'b1010, 4'b0000, 4'b0000, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] bb;
      bb = 4'(i + 1);
      addVec(0, 1, 1, 0, 4'h0, grayUp[i], bb, i == 15, bb == 4'hF, bb == 4'h0);
    end
    addVec(0, 0, 0, 1, 4'b1010, 4'b1111, 4'b1010, 0, 0, 0);
    addVec(0, 0, 0, 1, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0);
    addVec(0, 1, 0, 0, 4'h0,    4'b0000, 4'b0000, 0, 0, 1);
    addVec(0, 1, 0, 0, 4'h0,    4'b1000, 4'b1111, 1, 1, 0);
    addVec(0, 0, 0, 1, 4'b0101, 4'b0111, 4'b0101, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      addVec(0, 0, 1, 0, 4'h0,  4'b0111, 4'b0101, 0, 0, 0);
    addVec(0, 1, 1, 1, 4'b0011, 4'b0010, 4'b0011, 0, 0, 0);
    addVec(1, 0, 0, 1, 4'b1010, 4'b0000, 4'b0000, 0, 0, 1);

    foreach (vecs[i])
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv,
                    1, vecs[i].g, vecs[i].b, vecs[i].tc, vecs[i].mx, vecs[i].mn);

    // Saturating instance: pinned at the top while counting up, then steps back down.
    applyStimulus(0, 0, 0, 1, 4'b1111, 2, 4'b1000, 4'b1111, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 1, 0, 4'h0, 2, 4'b1000, 4'b1111, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 4'h0, 2, 4'b1001, 4'b1110, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 4'b0000, 2, 4'b0000, 4'b0000, 0, 0, 1);
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 1, 0, 0, 4'h0, 2, 4'b0000, 4'b0000, 0, 0, 1);

    for (int i = 0; i < 1000; i++) begin
      logic       r, e, u, l;
      logic [3:0] lv;
      r  = ($urandom_range(63) == 0);
      l  = ($urandom_range(7) == 0);
      e  = ($urandom_range(3) != 0);
      u  = 1'($urandom_range(1));
      lv = 4'($urandom_range(15));
      applyStimulus(r, e, u, l, lv, 0, 4'h0, 4'h0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
